// File: rtl/sprite_pkg.sv
// Shared sizes, row type, fetch FSM states and the row mirror helper for the
// sprite scanline fetch stage.
package sprite_pkg;

  localparam int SPR_W   = 32;
  localparam int SPR_H   = 32;
  localparam int ID_W    = 6;
  localparam int COORD_W = 10;

  localparam int ROW_AW = $clog2(SPR_H);
  localparam int COL_AW = $clog2(SPR_W);
  localparam int ROM_AW = ID_W + ROW_AW;

  typedef logic [SPR_W-1:0] spr_row_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    CAPT,
    DONE
  } fetch_state_t;

  function automatic spr_row_t bit_reverse(input spr_row_t r);
    spr_row_t o;
    for (int i = 0; i < SPR_W; i++) begin
      o[i] = r[SPR_W-1-i];
    end
    return o;
  endfunction

endpackage

// File: rtl/sprite_line_fetch_if.sv
// Address/data bus between the scanline fetch stage and sprite_rom.
// No valid/ready: master holds rom_addr stable for a full cycle before capturing rom_data.
interface sprite_line_fetch_if;
  import sprite_pkg::*;

  logic [ROM_AW-1:0] rom_addr;
  spr_row_t          rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);

endinterface

// File: rtl/sprite_line_fetch.sv
// Fetches the sprite row for the next scanline during hblank, double-buffers it
// and streams a registered pixel_on bit indexed by DrawX.
module sprite_line_fetch
  import sprite_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                line_start,
  input  logic                line_swap,
  input  logic [COORD_W-1:0]  next_y,
  input  logic                spr_en,
  input  logic [ID_W-1:0]     spr_id,
  input  logic [COORD_W-1:0]  spr_x,
  input  logic [COORD_W-1:0]  spr_y,
  input  logic                spr_hflip,
  sprite_line_fetch_if.master rom_bus,
  input  logic [COORD_W-1:0]  DrawX,
  output logic                pixel_on,
  output logic                busy,
  output logic                overrun,
  output fetch_state_t        dbg_state
);

  fetch_state_t       state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ROW_AW-1:0]  row_q, row_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic               hflip_q, hflip_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  spr_row_t           pend_row_q, pend_row_d;
  logic               pend_valid_q, pend_valid_d;
  logic [COORD_W-1:0] pend_x_q, pend_x_d;
  spr_row_t           act_row_q, act_row_d;
  logic               act_valid_q, act_valid_d;
  logic [COORD_W-1:0] act_x_q, act_x_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;
  logic               pixel_on_q, pixel_on_d;

  logic [COORD_W-1:0] dy;
  logic               start_hit;
  spr_row_t           capt_row;
  logic [COORD_W-1:0] col;
  logic [COL_AW-1:0]  bit_idx;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    row_d        = row_q;
    x_d          = x_q;
    hflip_d      = hflip_q;
    rom_addr_d   = rom_addr_q;
    pend_row_d   = pend_row_q;
    pend_valid_d = pend_valid_q;
    pend_x_d     = pend_x_q;
    act_row_d    = act_row_q;
    act_valid_d  = act_valid_q;
    act_x_d      = act_x_q;
    overrun_d    = overrun_q;

    dy        = next_y - spr_y;
    start_hit = spr_en && (dy < COORD_W'(SPR_H));
    capt_row  = hflip_q ? bit_reverse(rom_bus.rom_data) : rom_bus.rom_data;

    case (state_q)
      IDLE: begin
        if (line_swap) act_valid_d = 1'b0;
      end
      ADDR: begin
        rom_addr_d = {id_q, row_q};
        state_d    = CAPT;
        if (line_swap) begin
          act_valid_d = 1'b0;
          overrun_d   = 1'b1;
        end
      end
      CAPT: begin
        pend_row_d   = capt_row;
        pend_valid_d = 1'b1;
        pend_x_d     = x_q;
        state_d      = DONE;
        // A swap landing on the capture cycle takes the fresh row directly.
        if (line_swap) begin
          act_row_d   = capt_row;
          act_valid_d = 1'b1;
          act_x_d     = x_q;
          state_d     = IDLE;
        end
      end
      DONE: begin
        if (line_swap) begin
          act_row_d   = pend_row_q;
          act_valid_d = pend_valid_q;
          act_x_d     = pend_x_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The most recent line_start always wins, aborting any fetch in flight.
    if (line_start) begin
      id_d         = spr_id;
      row_d        = dy[ROW_AW-1:0];
      x_d          = spr_x;
      hflip_d      = spr_hflip;
      pend_valid_d = 1'b0;
      state_d      = start_hit ? ADDR : DONE;
    end

    busy_d = (state_d == ADDR) || (state_d == CAPT);

    col        = DrawX - act_x_q;
    bit_idx    = COL_AW'(SPR_W-1) - col[COL_AW-1:0];
    pixel_on_d = act_valid_q && (col < COORD_W'(SPR_W)) && act_row_q[bit_idx];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      id_q         <= '0;
      row_q        <= '0;
      x_q          <= '0;
      hflip_q      <= 1'b0;
      rom_addr_q   <= '0;
      pend_row_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_x_q     <= '0;
      act_row_q    <= '0;
      act_valid_q  <= 1'b0;
      act_x_q      <= '0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      pixel_on_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      row_q        <= row_d;
      x_q          <= x_d;
      hflip_q      <= hflip_d;
      rom_addr_q   <= rom_addr_d;
      pend_row_q   <= pend_row_d;
      pend_valid_q <= pend_valid_d;
      pend_x_q     <= pend_x_d;
      act_row_q    <= act_row_d;
      act_valid_q  <= act_valid_d;
      act_x_q      <= act_x_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      pixel_on_q   <= pixel_on_d;
    end
  end

  assign rom_bus.rom_addr = rom_addr_q;
  assign pixel_on         = pixel_on_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed and randomized scanline scenarios for sprite_line_fetch, checked
// against a painted-scanline reference model and a {addr, 21'h0} ROM model.
module tb_sprite_line_fetch;
  import sprite_pkg::*;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         line_start = 1'b0;
  logic         line_swap = 1'b0;
  logic [9:0]   next_y = '0;
  logic         spr_en = 1'b0;
  logic [5:0]   spr_id = '0;
  logic [9:0]   spr_x = '0;
  logic [9:0]   spr_y = '0;
  logic         spr_hflip = 1'b0;
  logic [9:0]   DrawX = '0;
  logic         pixel_on;
  logic         busy;
  logic         overrun;
  fetch_state_t dbg_state;

  int total = 0;
  int bad = 0;

  sprite_line_fetch_if rom_bus ();
  assign rom_bus.rom_data = {rom_bus.rom_addr, 21'h0};

  sprite_line_fetch dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .line_start (line_start),
    .line_swap  (line_swap),
    .next_y     (next_y),
    .spr_en     (spr_en),
    .spr_id     (spr_id),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_hflip  (spr_hflip),
    .rom_bus    (rom_bus),
    .DrawX      (DrawX),
    .pixel_on   (pixel_on),
    .busy       (busy),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model state
  logic        m_pend_valid = 1'b0;
  logic [31:0] m_pend_row = '0;
  logic [9:0]  m_pend_x = '0;
  logic        m_act_valid = 1'b0;
  logic [31:0] m_act_row = '0;
  logic [9:0]  m_act_x = '0;
  logic [10:0] m_rom_addr = '0;
  logic        img [1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mirror(input logic [31:0] r);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[i] = r[31-i];
    return o;
  endfunction

  task automatic model_fetch(input logic en, input logic [5:0] id, input logic [9:0] x,
                             input logic [9:0] y, input logic [9:0] ny, input logic hf);
    int row;
    row = (int'(ny) - int'(y) + 1024) % 1024;
    m_pend_valid = en && (row < 32);
    m_pend_row   = {id, 5'(row), 21'h0};
    if (hf) m_pend_row = mirror(m_pend_row);
    m_pend_x = x;
    if (m_pend_valid) m_rom_addr = {id, 5'(row)};
  endtask

  // driver tasks
  task automatic drive_start(input logic en, input logic [5:0] id, input logic [9:0] x,
                             input logic [9:0] y, input logic [9:0] ny, input logic hf);
    spr_en = en; spr_id = id; spr_x = x; spr_y = y; next_y = ny; spr_hflip = hf;
    line_start = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic fetch(input logic en, input logic [5:0] id, input logic [9:0] x,
                       input logic [9:0] y, input logic [9:0] ny, input logic hf);
    @(negedge Clk);
    drive_start(en, id, x, y, ny, hf);
    model_fetch(en, id, x, y, ny, hf);
    @(negedge Clk);
    line_start = 1'b0;
    chk("busy_addr", busy, m_pend_valid);
    @(negedge Clk);
    chk("rom_addr", rom_bus.rom_addr, m_rom_addr);
    chk("busy_capt", busy, m_pend_valid);
    @(negedge Clk);
    chk("busy_done", busy, 0);
    chk("state_done", dbg_state, DONE);
  endtask

  task automatic swap_commit();
    @(negedge Clk);
    line_swap = 1'b1;
    @(negedge Clk);
    line_swap = 1'b0;
    m_act_valid = m_pend_valid;
    m_act_row   = m_pend_row;
    m_act_x     = m_pend_x;
  endtask

  // scoreboard: paint the expected scanline, then compare a 0..639 sweep
  task automatic sweep(input string tag);
    logic [9:0] p;
    for (int i = 0; i < 1024; i++) img[i] = 1'b0;
    if (m_act_valid) begin
      for (int i = 0; i < 32; i++) begin
        p = m_act_x + 10'(i);
        img[p] = m_act_row[31-i];
      end
    end
    for (int x = 0; x <= 640; x++) begin
      @(negedge Clk);
      if (x > 0) chk(tag, pixel_on, img[x-1]);
      if (x < 640) DrawX = 10'(x);
    end
  endtask

  initial begin
    logic       r_en, r_hf;
    logic [5:0] r_id;
    logic [9:0] r_x, r_y, r_ny;

    // reset state
    wait_cycles(3);
    chk("rst_pixel", pixel_on, 0);
    chk("rst_addr", rom_bus.rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", dbg_state, IDLE);
    Reset_n = 1'b1;

    // 1: idle sweep
    sweep("idle_pix");
    chk("idle_addr", rom_bus.rom_addr, 0);
    chk("idle_busy", busy, 0);
    chk("idle_overrun", overrun, 0);

    // 2: basic fetch, id 3 row 5
    fetch(1'b1, 6'd3, 10'd200, 10'd100, 10'd105, 1'b0);
    chk("addr_065", rom_bus.rom_addr, 11'h065);
    wait_cycles(10);
    swap_commit();
    sweep("basic_pix");

    // 3: mirrored
    fetch(1'b1, 6'd3, 10'd200, 10'd100, 10'd105, 1'b1);
    wait_cycles(10);
    swap_commit();
    sweep("hflip_pix");

    // swap on the capture cycle bypasses into the active buffer
    @(negedge Clk);
    drive_start(1'b1, 6'd5, 10'd300, 10'd50, 10'd60, 1'b0);
    model_fetch(1'b1, 6'd5, 10'd300, 10'd50, 10'd60, 1'b0);
    @(negedge Clk);
    line_start = 1'b0;
    @(negedge Clk);
    line_swap = 1'b1;
    @(negedge Clk);
    line_swap = 1'b0;
    m_act_valid = m_pend_valid; m_act_row = m_pend_row; m_act_x = m_pend_x;
    chk("bypass_overrun", overrun, 0);
    chk("bypass_state", dbg_state, IDLE);
    sweep("bypass_pix");

    // 4: misses above/below, disabled, right-edge and left-wrap clipping
    fetch(1'b1, 6'd9, 10'd100, 10'd100, 10'd99, 1'b0);
    swap_commit();
    sweep("miss_above_pix");
    fetch(1'b1, 6'd9, 10'd100, 10'd100, 10'd132, 1'b0);
    swap_commit();
    sweep("miss_below_pix");
    fetch(1'b0, 6'd9, 10'd100, 10'd100, 10'd110, 1'b0);
    swap_commit();
    sweep("disabled_pix");
    fetch(1'b1, 6'd12, 10'd620, 10'd100, 10'd131, 1'b0);
    swap_commit();
    sweep("right_clip_pix");
    fetch(1'b1, 6'd1, 10'd1020, 10'd0, 10'd7, 1'b1);
    swap_commit();
    sweep("left_wrap_pix");

    // randomized lines
    repeat (6) begin
      r_en = ($urandom_range(0, 7) != 0);
      r_id = 6'($urandom_range(0, 63));
      r_y  = 10'($urandom_range(0, 479));
      r_ny = r_y + 10'($urandom_range(0, 40)) - 10'd4;
      r_x  = 10'($urandom_range(0, 1023));
      r_hf = 1'($urandom_range(0, 1));
      fetch(r_en, r_id, r_x, r_y, r_ny, r_hf);
      wait_cycles($urandom_range(0, 8));
      swap_commit();
      sweep("rand_pix");
    end

    // 5: swap one cycle after line_start
    chk("pre_overrun", overrun, 0);
    @(negedge Clk);
    drive_start(1'b1, 6'd20, 10'd64, 10'd10, 10'd30, 1'b0);
    model_fetch(1'b1, 6'd20, 10'd64, 10'd10, 10'd30, 1'b0);
    @(negedge Clk);
    line_start = 1'b0;
    line_swap = 1'b1;
    @(negedge Clk);
    line_swap = 1'b0;
    m_act_valid = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_cycles(3);
    chk("overrun_state", dbg_state, DONE);
    sweep("overrun_blank_pix");
    swap_commit();
    sweep("overrun_next_pix");
    chk("overrun_sticky", overrun, 1);

    // 6: restart in ADDR, last pulse wins
    @(negedge Clk);
    drive_start(1'b1, 6'd3, 10'd200, 10'd100, 10'd105, 1'b0);
    @(negedge Clk);
    drive_start(1'b1, 6'd7, 10'd200, 10'd100, 10'd105, 1'b0);
    model_fetch(1'b1, 6'd7, 10'd200, 10'd100, 10'd105, 1'b0);
    @(negedge Clk);
    line_start = 1'b0;
    @(negedge Clk);
    chk("restart_addr", rom_bus.rom_addr, 11'h0E5);
    chk("restart_state", dbg_state, CAPT);
    @(negedge Clk);
    chk("restart_done", dbg_state, DONE);
    swap_commit();
    sweep("restart_pix");

    // reset asserted during CAPT
    @(negedge Clk);
    drive_start(1'b1, 6'd30, 10'd0, 10'd0, 10'd0, 1'b0);
    @(negedge Clk);
    line_start = 1'b0;
    @(negedge Clk);
    chk("pre_rst_state", dbg_state, CAPT);
    Reset_n = 1'b0;
    #1;
    chk("midrst_addr", rom_bus.rom_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_pixel", pixel_on, 0);
    chk("midrst_state", dbg_state, IDLE);
    m_pend_valid = 1'b0; m_act_valid = 1'b0; m_rom_addr = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    swap_commit();
    sweep("post_rst_pix");
    chk("post_rst_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
